// File: rtl/router_mc.sv
// router_mc: byte-serial packet router with per-packet buffering and XOR check.
// A packet (DA, LEN, payload, CRC) is stored, verified, then replayed on output
// port DA. Bad packets are dropped and reported on a one-cycle error code.
// Optional feature macro: ROUTER_BCAST_EN (DA = all-ones replays on every port).
module router_mc #(
    parameter int DW        = 8,
    parameter int NUM_PORTS = 4,
    parameter int MAX_LEN   = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [DW-1:0]           dut_inp,
    input  logic                    inp_valid,
    output logic [NUM_PORTS*DW-1:0] dut_outp,
    output logic [NUM_PORTS-1:0]    outp_valid,
    output logic                    busy,
    output logic [3:0]              error
);

    localparam int DEPTH = MAX_LEN + 3;
    // Pointers must also hold DEPTH itself (end-of-replay marker).
    localparam int PW    = $clog2(DEPTH + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN, S_PAYLOAD, S_CRC, S_CHECK, S_DRAIN, S_SKIP
    } state_t;

    state_t          state_q, state_d;
    logic [DW-1:0]   da_q, da_d;
    logic [DW-1:0]   len_q, len_d;
    logic [DW-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]   xor_q, xor_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic            busy_q, busy_d;
    logic            valid_q, valid_d;
    logic [3:0]      error_q, error_d;
`ifdef ROUTER_BCAST_EN
    logic            bcast_q, bcast_d;
    logic            da_is_bcast;
`endif

    logic            wr_en;
    logic [PW-1:0]   wr_addr;
    logic [PW-1:0]   rd_addr;
    logic [PW-1:0]   total;
    logic            da_bad;
    logic            len_bad;
    logic [DW-1:0]   rd_data_q;
    logic [DW-1:0]   mem [0:DEPTH-1];

    assign total   = PW'(len_q) + PW'(3);
    assign len_bad = (dut_inp == '0) || (32'(dut_inp) > 32'(MAX_LEN));
`ifdef ROUTER_BCAST_EN
    assign da_is_bcast = (dut_inp == {DW{1'b1}});
    assign da_bad      = !da_is_bcast && (32'(dut_inp) >= 32'(NUM_PORTS));
`else
    assign da_bad      = (32'(dut_inp) >= 32'(NUM_PORTS));
`endif

    // Packet buffer: synchronous write of accepted bytes, registered replay read.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= dut_inp;
        end
        rd_data_q <= mem[rd_addr];
    end

    // Next-state, buffer control and error code for the receive/check/replay FSM.
    always_comb begin
        state_d  = state_q;
        da_d     = da_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        xor_d    = xor_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        busy_d   = busy_q;
        valid_d  = valid_q;
        error_d  = 4'd0;
        wr_en    = 1'b0;
        wr_addr  = wr_ptr_q;
        rd_addr  = '0;
`ifdef ROUTER_BCAST_EN
        bcast_d  = bcast_q;
`endif
        case (state_q)
            S_IDLE: begin
                wr_addr = '0;
                if (inp_valid) begin
                    wr_en    = 1'b1;
                    wr_ptr_d = PW'(1);
                    xor_d    = dut_inp;
                    da_d     = dut_inp;
`ifdef ROUTER_BCAST_EN
                    bcast_d  = da_is_bcast;
`endif
                    if (da_bad) begin
                        error_d = 4'd2;
                        state_d = S_SKIP;
                    end else begin
                        state_d = S_LEN;
                    end
                end
            end
            S_LEN: begin
                if (!inp_valid) begin
                    error_d = 4'd5;
                    state_d = S_IDLE;
                end else begin
                    wr_en    = 1'b1;
                    wr_ptr_d = wr_ptr_q + PW'(1);
                    xor_d    = xor_q ^ dut_inp;
                    len_d    = dut_inp;
                    cnt_d    = dut_inp;
                    if (len_bad) begin
                        error_d = 4'd3;
                        state_d = S_SKIP;
                    end else begin
                        state_d = S_PAYLOAD;
                    end
                end
            end
            S_PAYLOAD: begin
                if (!inp_valid) begin
                    error_d = 4'd5;
                    state_d = S_IDLE;
                end else begin
                    wr_en    = 1'b1;
                    wr_ptr_d = wr_ptr_q + PW'(1);
                    xor_d    = xor_q ^ dut_inp;
                    cnt_d    = cnt_q - DW'(1);
                    if (cnt_q == DW'(1)) begin
                        state_d = S_CRC;
                    end
                end
            end
            S_CRC: begin
                if (!inp_valid) begin
                    error_d = 4'd5;
                    state_d = S_IDLE;
                end else begin
                    wr_en   = 1'b1;
                    xor_d   = xor_q ^ dut_inp;
                    busy_d  = 1'b1;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                // The CRC byte is folded in, so a good packet leaves a zero residue.
                if (xor_q != '0) begin
                    error_d = 4'd1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    rd_addr  = '0;
                    rd_ptr_d = PW'(1);
                    valid_d  = 1'b1;
                    state_d  = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (rd_ptr_q == total) begin
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    rd_addr  = rd_ptr_q;
                    rd_ptr_d = rd_ptr_q + PW'(1);
                end
            end
            S_SKIP: begin
                if (!inp_valid) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // A refused byte is only reported when no CHECK error claims the cycle.
        if (busy_q && inp_valid && (error_d == 4'd0)) begin
            error_d = 4'd4;
        end
    end

    // State and control registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            da_q     <= '0;
            len_q    <= '0;
            cnt_q    <= '0;
            xor_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            error_q  <= 4'd0;
`ifdef ROUTER_BCAST_EN
            bcast_q  <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            da_q     <= da_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            xor_q    <= xor_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            busy_q   <= busy_d;
            valid_q  <= valid_d;
            error_q  <= error_d;
`ifdef ROUTER_BCAST_EN
            bcast_q  <= bcast_d;
`endif
        end
    end

    assign busy  = busy_q;
    assign error = error_q;

    // Per-port steering: only the addressed port sees data, idle ports read zero.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
`ifdef ROUTER_BCAST_EN
            assign outp_valid[gi] = valid_q && (bcast_q || (da_q == DW'(gi)));
`else
            assign outp_valid[gi] = valid_q && (da_q == DW'(gi));
`endif
            assign dut_outp[gi*DW +: DW] = outp_valid[gi] ? rd_data_q : '0;
        end
    endgenerate

endmodule
